// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sequencer and its ALU: data width,
// ALU operation codes and the sequencer state encoding.
package cordic_pkg;

    localparam int Q_W    = 16;
    localparam int Q_FRAC = 13;

    typedef enum logic [2:0] {
        SHIFT_A_WITH_B     = 3'd0,
        SIGN_MULT_A_WITH_B = 3'd3,
        ADD_A_WITH_B       = 3'd5,
        ALU_IDLE           = 3'd7
    } alu_mode_e;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        SHX   = 4'd1,
        SHY   = 4'd2,
        SGN_Y = 4'd3,
        ADD_X = 4'd4,
        SGN_X = 4'd5,
        ADD_Y = 4'd6,
        SGN_Z = 4'd7,
        ADD_Z = 4'd8,
        DONE  = 4'd9
    } state_e;

endpackage

// File: rtl/cordic_alu.sv
// Shared combinational CORDIC ALU: arithmetic shift, conditional negate, add.
module cordic_alu
    import cordic_pkg::*;
(
    input  logic [2:0]     mode,
    input  logic [Q_W-1:0] op_a,
    input  logic [Q_W-1:0] op_b,
    input  logic [Q_W-1:0] op_c,
    output logic [Q_W-1:0] res
);

    localparam logic [Q_W-1:0] ONE = Q_W'(1);

    always_comb begin
        res = '0;
        case (alu_mode_e'(mode))
            SHIFT_A_WITH_B:     res = Q_W'($signed(op_a) >>> op_b[3:0]);
            SIGN_MULT_A_WITH_B: res = (op_b == ONE) ? Q_W'(-$signed(op_a)) : op_a;
            // op_c is a carry-style third term; the sequencer always drives it 0
            ADD_A_WITH_B:       res = op_a + op_b + op_c;
            default:            res = '0;
        endcase
    end

endmodule

// File: rtl/cordic_atan_rom.sv
// Arctangent table: atan(2^-idx) in Q3.13 radians, rounded to nearest.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [3:0]     idx,
    output logic [Q_W-1:0] atan
);

    always_comb begin
        atan = '0;
        case (idx)
            4'd0:  atan = 16'd6434;
            4'd1:  atan = 16'd3798;
            4'd2:  atan = 16'd2007;
            4'd3:  atan = 16'd1019;
            4'd4:  atan = 16'd511;
            4'd5:  atan = 16'd256;
            4'd6:  atan = 16'd128;
            4'd7:  atan = 16'd64;
            4'd8:  atan = 16'd32;
            4'd9:  atan = 16'd16;
            4'd10: atan = 16'd8;
            4'd11: atan = 16'd4;
            4'd12: atan = 16'd2;
            4'd13: atan = 16'd1;
            4'd14: atan = 16'd0;
            4'd15: atan = 16'd0;
        endcase
    end

endmodule

// File: rtl/cordic_ctrl.sv
// CORDIC rotation sequencer driving an external shared ALU, one ALU op per cycle.
//
// state | meaning
// IDLE  | waiting for start_i, loads x/y/z and angle sign
// SHX   | xs <= x >>> i
// SHY   | ys <= y >>> i
// SGN_Y | t  <= zneg ? ys : -ys
// ADD_X | x  <= x + t
// SGN_X | t  <= zneg ? -xs : xs
// ADD_Y | y  <= y + t
// SGN_Z | t  <= zneg ? atan(i) : -atan(i)
// ADD_Z | z  <= z + t, next iteration or finish
// DONE  | publish results, pulse done_o
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int ITER = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [Q_W-1:0] x_i,
    input  logic [Q_W-1:0] y_i,
    input  logic [Q_W-1:0] z_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [Q_W-1:0] x_o,
    output logic [Q_W-1:0] y_o,
    output logic [Q_W-1:0] z_o,
    output logic [Q_W-1:0] alu_op_a_o,
    output logic [Q_W-1:0] alu_op_b_o,
    output logic [Q_W-1:0] alu_op_c_o,
    output logic [2:0]     alu_mode_o,
    input  logic [Q_W-1:0] alu_res_i
);

    localparam logic [3:0] I_LAST = 4'(ITER - 1);

    state_e         state, state_nxt;
    logic [Q_W-1:0] x, y, z, xs, ys, t;
    logic [3:0]     i;
    logic           zneg;
    logic [Q_W-1:0] atan_i;

    cordic_atan_rom u_atan_rom (
        .idx  (i),
        .atan (atan_i)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy_o     = !rst;
        done_o     = 1'b0;
        alu_mode_o = ALU_IDLE;
        alu_op_a_o = '0;
        alu_op_b_o = '0;
        alu_op_c_o = '0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_nxt = SHX;
            end
            SHX: begin
                alu_mode_o = SHIFT_A_WITH_B;
                alu_op_a_o = x;
                alu_op_b_o = {12'b0, i};
                state_nxt  = SHY;
            end
            SHY: begin
                alu_mode_o = SHIFT_A_WITH_B;
                alu_op_a_o = y;
                alu_op_b_o = {12'b0, i};
                state_nxt  = SGN_Y;
            end
            SGN_Y: begin
                alu_mode_o = SIGN_MULT_A_WITH_B;
                alu_op_a_o = ys;
                alu_op_b_o = {15'b0, ~zneg};
                state_nxt  = ADD_X;
            end
            ADD_X: begin
                alu_mode_o = ADD_A_WITH_B;
                alu_op_a_o = x;
                alu_op_b_o = t;
                state_nxt  = SGN_X;
            end
            SGN_X: begin
                alu_mode_o = SIGN_MULT_A_WITH_B;
                alu_op_a_o = xs;
                alu_op_b_o = {15'b0, zneg};
                state_nxt  = ADD_Y;
            end
            ADD_Y: begin
                alu_mode_o = ADD_A_WITH_B;
                alu_op_a_o = y;
                alu_op_b_o = t;
                state_nxt  = SGN_Z;
            end
            SGN_Z: begin
                alu_mode_o = SIGN_MULT_A_WITH_B;
                alu_op_a_o = atan_i;
                alu_op_b_o = {15'b0, ~zneg};
                state_nxt  = ADD_Z;
            end
            ADD_Z: begin
                alu_mode_o = ADD_A_WITH_B;
                alu_op_a_o = z;
                alu_op_b_o = t;
                state_nxt  = (i == I_LAST) ? DONE : SHX;
            end
            DONE: begin
                done_o    = !rst;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            z    <= '0;
            xs   <= '0;
            ys   <= '0;
            t    <= '0;
            i    <= '0;
            zneg <= 1'b0;
            x_o  <= '0;
            y_o  <= '0;
            z_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        x    <= x_i;
                        y    <= y_i;
                        z    <= z_i;
                        i    <= '0;
                        zneg <= z_i[Q_W-1];
                    end
                end
                SHX:   xs <= alu_res_i;
                SHY:   ys <= alu_res_i;
                SGN_Y: t  <= alu_res_i;
                ADD_X: x  <= alu_res_i;
                SGN_X: t  <= alu_res_i;
                ADD_Y: y  <= alu_res_i;
                SGN_Z: t  <= alu_res_i;
                ADD_Z: begin
                    z <= alu_res_i;
                    // rotation direction for the next step follows the residual angle
                    if (i != I_LAST) begin
                        i    <= i + 4'd1;
                        zneg <= alu_res_i[Q_W-1];
                    end
                end
                DONE: begin
                    x_o <= x;
                    y_o <= y;
                    z_o <= z;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cordic_ctrl.md
CORDIC_CTRL -- requirements
Module: cordic_ctrl

Interface
REQ-001 The block SHALL have parameter ITER, default 16, number of CORDIC iterations; legal range 1..16.
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 The block SHALL have port start_i  input  1  request new rotation; sampled only in IDLE.
REQ-005 The block SHALL have ports x_i, y_i, z_i  input  16 each  signed start vector and angle; angle in Q3.13 radians.
REQ-006 The block SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-007 The block SHALL have port done_o  output  1  one-cycle pulse when results are final.
REQ-008 The block SHALL have ports x_o, y_o, z_o  output  16 each  signed result registers.
REQ-009 The block SHALL have ports alu_op_a_o, alu_op_b_o, alu_op_c_o  output  16 each  operands to the shared CORDIC ALU.
REQ-010 The block SHALL have port alu_mode_o  output  3  ALU operation code.
REQ-011 The block SHALL have port alu_res_i  input  16  combinational ALU result.

Function
REQ-012 ALU codes SHALL be: SHIFT_A_WITH_B=0, SIGN_MULT_A_WITH_B=3, ADD_A_WITH_B=5, ALU_IDLE=7; SIGN_MULT negates A when B==1.
REQ-013 The FSM SHALL have states IDLE, SHX, SHY, SGN_Y, ADD_X, SGN_X, ADD_Y, SGN_Z, ADD_Z, DONE.
REQ-014 In IDLE, start_i=1 SHALL load x,y,z working registers from x_i,y_i,z_i, clear iteration counter i, latch zneg=z_i[15], and go to SHX.
REQ-015 Per iteration, each ALU state lasts exactly 1 cycle and its alu_res_i is registered at the state's closing edge:
- SHX: A=x, B=i, mode 0 -> xs
- SHY: A=y, B=i, mode 0 -> ys
- SGN_Y: A=ys, B=~zneg, mode 3 -> t
- ADD_X: A=x, B=t, mode 5 -> x
- SGN_X: A=xs, B=zneg, mode 3 -> t
- ADD_Y: A=y, B=t, mode 5 -> y
- SGN_Z: A=atan(i), B=~zneg, mode 3 -> t
- ADD_Z: A=z, B=t, mode 5 -> z
REQ-016 B operands for sign-mult SHALL be zero-extended 1-bit flags; alu_op_c_o SHALL be 0 always.
REQ-017 At ADD_Z, if i==ITER-1 go to DONE; else i<=i+1, zneg<=sign of new z, go to SHX.
REQ-018 DONE SHALL copy x,y,z to x_o,y_o,z_o, assert done_o for exactly that cycle, then return to IDLE.
REQ-019 Latency: start accepted at edge k -> done_o high in the cycle following edge k+8*ITER; busy_o high from edge k to edge k+8*ITER+1.
REQ-020 start_i while busy_o=1 SHALL be ignored; start_i in the DONE cycle SHALL be ignored.
REQ-021 In IDLE and DONE, alu_mode_o SHALL be ALU_IDLE and all ALU operands 0.
REQ-022 All arithmetic SHALL be 16-bit two's complement wrap-around; no saturation.
REQ-023 x_o,y_o,z_o SHALL hold their values until the next DONE.

Reset
REQ-024 rst=1 at any edge, including mid-iteration, SHALL force IDLE, i=0, zneg=0, and clear all working registers and x_o,y_o,z_o.
REQ-025 busy_o and done_o SHALL be 0 during and after reset; start_i in a reset cycle SHALL be ignored.

Structure
REQ-026 ALU mode codes, FSM state encoding and the Q3.13 format width SHALL be in shared package cordic_pkg, also used by the ALU.
REQ-027 The arctangent table SHALL be sub-module cordic_atan_rom (4-bit index, 16-bit Q3.13 output, combinational): atan(2^-i), entries 0..3 = 6434, 3798, 2007, 1019.
REQ-028 The ALU SHALL be instantiated outside this block; the bench SHALL connect the real ALU.

Verification
REQ-029 x=4975,y=0,z=0, start -> done_o after 129 cycles; x_o=8192±8, y_o=0±8, z_o=0±8.
REQ-030 x=4975,y=0,z=6434 -> x_o=5793±8, y_o=5793±8, z_o=0±8.
REQ-031 x=4975,y=0,z=-6434 -> x_o=5793±8, y_o=-5793±8.
REQ-032 start_i held high through a run -> exactly one done_o pulse per 130 cycles; second start accepted only from IDLE.
REQ-033 rst pulsed at iteration 5 -> next cycle busy_o=0, outputs 0, alu_mode_o=7; new start runs normally.
REQ-034 ITER=1, z=6434 -> done_o 9 cycles after accept; z_o=0, x_o=y_o=4975.
